// File: rtl/ram_pkg.sv
// Shared definitions for the two-port arbitrated RAM.
//   DefAddrW / DefDataW : default address and data widths
//   state_e             : arbiter FSM states
package ram_pkg;

    localparam int unsigned DefAddrW = 2;
    localparam int unsigned DefDataW = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_core.sv
// Single-port storage array with a registered read port.
//   clk, reset : clock, asynchronous active-high clear of array and read register
//   wr_en      : write wdata into mem[addr] at the rising edge
//   rd_en      : capture mem[addr] into rdata at the rising edge
//   addr       : word address
//   wdata      : write data
//   rdata      : registered read data, held until the next read
module ram_core #(
    parameter int unsigned ADDR_W = ram_pkg::DefAddrW,
    parameter int unsigned DATA_W = ram_pkg::DefDataW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned Words = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [Words];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Words; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[addr] <= wdata;
            end
            if (rd_en) begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a small RAM.
//   clk, reset       : clock, asynchronous active-high reset
//   req0/req1        : access requests, held until the matching gnt
//   we0/we1          : 1 = write, 0 = read
//   addr0/addr1      : word addresses
//   wdata0/wdata1    : write data
//   gnt0/gnt1        : one-cycle pulse while the accepted command is in ACCESS
//   rvalid0/rvalid1  : one-cycle pulse qualifying rdata for that requester
//   rdata            : shared read data
//   busy             : high whenever the FSM is not idle
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    state_e state_q, state_d;

    logic              last_grant_q;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic accept;
    logic winner;
    logic wr_en;
    logic rd_en;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        accept = (state_q == StIdle) && (req0 || req1);
        winner = (req0 && req1) ? ~last_grant_q : req1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StAccess;
            StAccess: state_d = we_q ? StIdle : StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Command latch: captured once at acceptance so later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (accept) begin
            last_grant_q <= winner;
            win_q        <= winner;
            we_q         <= winner ? we1 : we0;
            addr_q       <= winner ? addr1 : addr0;
            wdata_q      <= winner ? wdata1 : wdata0;
        end
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        busy    = (state_q != StIdle);
        unique case (state_q)
            StAccess: begin
                gnt0  = ~win_q;
                gnt1  = win_q;
                wr_en = we_q;
                rd_en = ~we_q;
            end
            StResp: begin
                rvalid0 = ~win_q;
                rvalid1 = win_q;
            end
            default: ;
        endcase
    end

    ram_core #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [1:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [3:0] rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .rvalid0(rvalid0),
        .rvalid1(rvalid1),
        .rdata  (rdata),
        .busy   (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic apply_reset();
        reset = 1;
        clear_inputs();
        tick();
        reset = 0;
    endtask

    task automatic issue(input bit who, input bit we, input logic [1:0] a, input logic [3:0] d);
        if (who) begin
            req1 = 1; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic drop(input bit who);
        if (who) req1 = 0;
        else     req0 = 0;
    endtask

    // Runs one write from idle; ok reports whether grant and 2-cycle occupancy were seen.
    task automatic do_write(input bit who, input logic [1:0] a, input logic [3:0] d,
                            output bit ok);
        issue(who, 1'b1, a, d);
        tick();
        ok = ((who ? gnt1 : gnt0) === 1'b1) && ((who ? gnt0 : gnt1) === 1'b0);
        drop(who);
        tick();
        ok = ok && (busy === 1'b0);
    endtask

    // Runs one read from idle; ok reports gnt at +1, rvalid at +2 and idle at +3.
    task automatic do_read(input bit who, input logic [1:0] a, output logic [3:0] data,
                           output bit ok);
        issue(who, 1'b0, a, 4'h0);
        tick();
        ok = ((who ? gnt1 : gnt0) === 1'b1);
        drop(who);
        tick();
        ok = ok && ((who ? rvalid1 : rvalid0) === 1'b1) && ((who ? rvalid0 : rvalid1) === 1'b0);
        data = rdata;
        tick();
        ok = ok && (busy === 1'b0);
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        reset = 1;
        clear_inputs();
        #3;
        outs = {gnt0, gnt1, rvalid0, rvalid1, busy, 3'b0};
        checks++;
        if (outs !== 8'h00 || rdata !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs: got flags=%b rdata=%h expected 00000 rdata=0",
                     outs[7:3], rdata);
        end
        tick();
        reset = 0;
        // Reset arriving mid-read must kill the access with no rvalid.
        issue(1'b1, 1'b0, 2'd2, 4'h0);
        tick();
        drop(1'b1);
        #2 reset = 1;
        #1;
        checks++;
        if (busy !== 1'b0 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_read: got busy=%b gnt1=%b expected 0 0", busy, gnt1);
        end
        #1 reset = 0;
        tick();
        checks++;
        if (rvalid1 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_rvalid: got rvalid1=%b busy=%b expected 0 0", rvalid1, busy);
        end
    endtask

    task automatic test_read_after_reset();
        logic [3:0] d;
        bit ok;
        apply_reset();
        do_read(1'b1, 2'd2, d, ok);
        checks++;
        if (!ok || d !== 4'h0) begin
            failures++;
            $display("FAIL read_after_reset: got ok=%0b rdata=%h expected 1 0", ok, d);
        end
    endtask

    task automatic test_write_read();
        logic [3:0] d;
        bit ok;
        do_write(1'b0, 2'd1, 4'hA, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_handshake: got ok=0 expected 1");
        end
        do_read(1'b1, 2'd1, d, ok);
        checks++;
        if (!ok || d !== 4'hA) begin
            failures++;
            $display("FAIL write_then_read: got ok=%0b rdata=%h expected 1 a", ok, d);
        end
    endtask

    task automatic test_contention();
        bit exp_g0 [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        bit exp_g1 [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        apply_reset();
        issue(1'b0, 1'b0, 2'd0, 4'h0);
        issue(1'b1, 1'b0, 2'd0, 4'h0);
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (gnt0 !== exp_g0[k] || gnt1 !== exp_g1[k]) begin
                failures++;
                $display("FAIL contention_step%0d: got gnt0=%b gnt1=%b expected %b %b",
                         k, gnt0, gnt1, exp_g0[k], exp_g1[k]);
            end
        end
        drop(1'b0);
        drop(1'b1);
    endtask

    task automatic test_req_during_resp();
        logic [3:0] d;
        bit ok;
        issue(1'b1, 1'b0, 2'd1, 4'h0);
        tick();
        drop(1'b1);
        tick();
        checks++;
        if (rvalid1 !== 1'b1) begin
            failures++;
            $display("FAIL resp_rvalid1: got %b expected 1", rvalid1);
        end
        issue(1'b0, 1'b1, 2'd2, 4'h6);
        tick();
        checks++;
        if (gnt0 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL resp_ignored: got gnt0=%b busy=%b expected 0 0", gnt0, busy);
        end
        tick();
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL resp_pending_gnt0: got %b expected 1", gnt0);
        end
        drop(1'b0);
        tick();
        do_read(1'b1, 2'd2, d, ok);
        checks++;
        if (!ok || d !== 4'h6) begin
            failures++;
            $display("FAIL resp_not_dropped: got ok=%0b rdata=%h expected 1 6", ok, d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [3:0] d;
        bit ok;
        issue(1'b0, 1'b1, 2'd3, 4'h5);
        tick();
        drop(1'b0);
        #2 reset = 1;
        #1;
        checks++;
        if (busy !== 1'b0 || gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_write_busy: got busy=%b gnt0=%b expected 0 0", busy, gnt0);
        end
        #1 reset = 0;
        tick();
        do_read(1'b1, 2'd3, d, ok);
        checks++;
        if (!ok || d !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid_write_mem: got ok=%0b rdata=%h expected 1 0", ok, d);
        end
    endtask

    task automatic test_latched_fields();
        logic [3:0] d;
        bit ok;
        issue(1'b0, 1'b1, 2'd0, 4'h7);
        tick();
        req0 = 0; addr0 = 2'd3; wdata0 = 4'hF;
        tick();
        do_read(1'b1, 2'd0, d, ok);
        checks++;
        if (!ok || d !== 4'h7) begin
            failures++;
            $display("FAIL latched_addr0: got ok=%0b rdata=%h expected 1 7", ok, d);
        end
        do_read(1'b0, 2'd3, d, ok);
        checks++;
        if (!ok || d !== 4'h0) begin
            failures++;
            $display("FAIL latched_addr3: got ok=%0b rdata=%h expected 1 0", ok, d);
        end
    endtask

    // Transaction-level model: an accepted write keeps the arbiter busy for 2 cycles,
    // a read for 3; a new command can only be accepted once that time has elapsed.
    task automatic test_random();
        logic [3:0] mmem [4];
        logic [3:0] mrdata;
        bit         mlast, has_txn, t_who, t_we, w;
        logic [1:0] t_addr;
        logic [3:0] t_data;
        int         acc_edge, next_acc, len, a;
        bit         pend [2];
        bit         cwe [2];
        logic [1:0] caddr [2];
        logic [3:0] cdata [2];
        bit         e_busy, e_g0, e_g1, e_v0, e_v1;

        apply_reset();
        for (int i = 0; i < 4; i++) mmem[i] = '0;
        mrdata = '0; mlast = 1; has_txn = 0; next_acc = 0; acc_edge = 0; len = 2;
        t_who = 0; t_we = 0; t_addr = '0; t_data = '0;
        pend[0] = 0; pend[1] = 0;

        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r]  = 1;
                    cwe[r]   = 1'($urandom);
                    caddr[r] = 2'($urandom);
                    cdata[r] = 4'($urandom);
                end
            end
            // Idle requesters wiggle their fields to show they are ignored.
            req0   = pend[0];
            we0    = pend[0] ? cwe[0]   : 1'($urandom);
            addr0  = pend[0] ? caddr[0] : 2'($urandom);
            wdata0 = pend[0] ? cdata[0] : 4'($urandom);
            req1   = pend[1];
            we1    = pend[1] ? cwe[1]   : 1'($urandom);
            addr1  = pend[1] ? caddr[1] : 2'($urandom);
            wdata1 = pend[1] ? cdata[1] : 4'($urandom);
            tick();

            if (has_txn && n == acc_edge + 1) begin
                if (t_we) mmem[t_addr] = t_data;
                else      mrdata = mmem[t_addr];
            end
            if (n >= next_acc && (pend[0] || pend[1])) begin
                w        = (pend[0] && pend[1]) ? !mlast : pend[1];
                mlast    = w;
                has_txn  = 1;
                t_who    = w;
                t_we     = cwe[w];
                t_addr   = caddr[w];
                t_data   = cdata[w];
                acc_edge = n;
                len      = t_we ? 2 : 3;
                next_acc = n + len;
            end

            a      = n - acc_edge;
            e_busy = has_txn && (a < len - 1);
            e_g0   = has_txn && (a == 0) && !t_who;
            e_g1   = has_txn && (a == 0) && t_who;
            e_v0   = has_txn && (a == 1) && !t_we && !t_who;
            e_v1   = has_txn && (a == 1) && !t_we && t_who;

            checks++;
            if ({busy, gnt0, gnt1, rvalid0, rvalid1} !== {e_busy, e_g0, e_g1, e_v0, e_v1}) begin
                failures++;
                $display("FAIL random_ctrl cycle %0d: got busy/g0/g1/v0/v1=%b expected %b", n,
                         {busy, gnt0, gnt1, rvalid0, rvalid1}, {e_busy, e_g0, e_g1, e_v0, e_v1});
            end
            checks++;
            if (rdata !== mrdata) begin
                failures++;
                $display("FAIL random_rdata cycle %0d: got %h expected %h", n, rdata, mrdata);
            end

            if (has_txn && a == 0) pend[t_who] = 0;

            if (n == 200) begin
                reset = 1;
                #1;
                checks++;
                if (busy !== 1'b0 || rdata !== 4'h0) begin
                    failures++;
                    $display("FAIL random_reset: got busy=%b rdata=%h expected 0 0", busy, rdata);
                end
                for (int i = 0; i < 4; i++) mmem[i] = '0;
                mrdata = '0; mlast = 1; has_txn = 0; next_acc = n + 1;
                pend[0] = 0; pend[1] = 0;
                #1 reset = 0;
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_contention();
        test_req_during_resp();
        test_reset_mid_write();
        test_latched_fields();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 2, address width; the RAM holds 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 4, data word width.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1.
REQ-006 we0 / we1  input  1  1 = write, 0 = read, for requester 0 / 1.
REQ-007 addr0 / addr1  input  ADDR_W  word address for requester 0 / 1.
REQ-008 wdata0 / wdata1  input  DATA_W  write data for requester 0 / 1.
REQ-009 gnt0 / gnt1  output  1  one-cycle grant pulse, issued when the command is accepted.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse; rdata holds read data for that requester.
REQ-011 rdata  output  DATA_W  read data shared by both requesters; qualified only by rvalid0/rvalid1.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-014 IDLE: if any reqN is sampled high at an edge, the block SHALL latch that requester's we/addr/wdata and the winner index, then go to ACCESS. Otherwise it stays in IDLE.
REQ-015 ACCESS: gnt of the winner SHALL be high for exactly this one cycle.
REQ-016 ACCESS, write: mem[addr] <= wdata at the ACCESS-exit edge, then IDLE.
REQ-017 ACCESS, read: rdata <= mem[addr] at the ACCESS-exit edge, then RESP.
REQ-018 RESP: rvalid of the winner SHALL be high for exactly one cycle, then IDLE.
REQ-019 Latency from the req-sampling edge: gnt appears 1 cycle later; read data/rvalid appear 2 cycles later.
REQ-020 Occupancy: a write occupies 2 cycles and a read 3 cycles; there is no pipelining.
REQ-021 Arbitration SHALL be round-robin via a 1-bit last_grant register, updated at each acceptance.
REQ-022 If req0 and req1 are both high in IDLE, the requester not equal to last_grant SHALL win.
REQ-023 If only one request is high, it SHALL win regardless of last_grant.
REQ-024 Requests SHALL be ignored outside IDLE; a requester holds req/we/addr/wdata until its gnt, then deasserts req.
REQ-025 A req still high in the IDLE cycle after completion SHALL be treated as a new request.
REQ-026 A loser's request stays pending and SHALL be served at the next IDLE.
REQ-027 Latched command fields SHALL be used for the whole access; input changes after acceptance have no effect.
REQ-028 rdata SHALL hold its last read value until the next read completes; writes never alter rdata.
REQ-029 gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.
REQ-030 No write to memory occurs except in ACCESS with latched we = 1.

Reset
REQ-031 reset SHALL act immediately, independent of clk, including mid-access.
REQ-032 On reset: state = IDLE; every memory word = 0; rdata = 0.
REQ-033 On reset: gnt0, gnt1, rvalid0, rvalid1 and busy = 0.
REQ-034 On reset: last_grant = 1, so requester 0 wins the first contention.
REQ-035 A write in ACCESS when reset asserts SHALL be discarded; memory reads 0.
REQ-036 A read in ACCESS or RESP when reset asserts SHALL be discarded; no rvalid pulse is issued.

Structure
REQ-037 ADDR_W and DATA_W defaults and the FSM state enum SHALL live in a shared package, ram_pkg.
REQ-038 Storage SHALL be a sub-module, ram_core: a synchronous write-enabled array with registered read output and async clear on reset.
REQ-039 The arbiter FSM, round-robin pointer and command latch SHALL live in ram_arbiter.

Verification
REQ-040 Reset, then read addr 2 from requester 1: gnt1 at +1 cycle, rvalid1 at +2, rdata = 0.
REQ-041 Requester 0 writes 4'hA to addr 1, then requester 1 reads addr 1: rvalid1 with rdata = 4'hA.
REQ-042 req0 and req1 raised together after reset: gnt0 first. Both held raised: gnt1 next, then gnt0 (alternation).
REQ-043 Requester 0 requests while requester 1's read is in RESP: no gnt0 until IDLE, then gnt0 with no dropped transaction.
REQ-044 Requester 0 writes 4'h5 to addr 3 and reset asserts during ACCESS: busy = 0 immediately, and a later read of addr 3 returns 0.
REQ-045 Requester 0 changes addr0 from 0 to 3 in ACCESS after writing 4'h7: only addr 0 = 4'h7, and addr 3 is unchanged.
